edge_slope_setup: RTL

Per-triangle setup stage for the rasteriser edge walker. It latches three screen-space vertices and computes the fixed-point dx/dy slope of edges 0-1, 0-2 and 1-2. It issues one divide at a time to the 16-bit signed divider wrapper, consumes each quotient, and presents all three slopes together with a done pulse. It is both the producer of operands for the divider and the consumer of its results.

---
 rtl/edge_slope_setup_if.sv | 18 +
 rtl/edge_slope_setup.sv | 125 ++++++++++++
 2 files changed

// File: rtl/edge_slope_setup_if.sv
// Operand/result handshake between the edge slope setup stage and the shared signed divider.
interface edge_slope_setup_if;
    logic               div_open;
    logic signed [15:0] div_dividend;
    logic signed [15:0] div_divisor;
    logic               div_finish;
    logic signed [15:0] div_quotient;

    modport master (
        output div_open, div_dividend, div_divisor,
        input  div_finish, div_quotient
    );

    modport slave (
        input  div_open, div_dividend, div_divisor,
        output div_finish, div_quotient
    );
endinterface

// File: rtl/edge_slope_setup.sv
// Per-triangle dx/dy slope setup for edges 0-1, 0-2, 1-2; one divide outstanding at a time.
// Done 1 cycle after the last slope write; stalls indefinitely in WAIT until the divider answers.
module edge_slope_setup #(
    parameter int FRAC_BITS = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic signed [15:0] x0,
    input  logic signed [15:0] y0,
    input  logic signed [15:0] x1,
    input  logic signed [15:0] y1,
    input  logic signed [15:0] x2,
    input  logic signed [15:0] y2,
    output logic               busy,
    output logic               done,
    output logic signed [15:0] slope01,
    output logic signed [15:0] slope02,
    output logic signed [15:0] slope12,
    edge_slope_setup_if.master div
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t             state, state_nxt;
    logic [1:0]         idx;
    logic signed [15:0] vx0, vy0, vx1, vy1, vx2, vy2;

    logic               start_acc, advance, op_load;
    logic [1:0]         op_idx;
    logic signed [15:0] px0, py0, px1, py1, px2, py2;
    logic signed [15:0] ax, ay, bx, by;
    logic signed [16:0] dx, dy;
    logic signed [24:0] num_w, den_w;
    logic signed [15:0] num, den, wr_val;

    function automatic logic signed [15:0] sat16(input logic signed [24:0] v);
        if (v > 25'sd32767)
            return 16'sh7fff;
        else if (v < -25'sd32768)
            return 16'sh8000;
        else
            return v[15:0];
    endfunction

    always_comb begin
        state_nxt = state;
        start_acc = 1'b0;
        advance   = 1'b0;
        case (state)
            IDLE:  if (start) begin
                       start_acc = 1'b1;
                       state_nxt = ISSUE;
                   end
            ISSUE: if (div.div_divisor == 16'sd0) advance = 1'b1;
                   else                           state_nxt = WAIT;
            WAIT:  if (div.div_finish) advance = 1'b1;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (advance)
            state_nxt = (idx == 2'd2) ? DONE : ISSUE;
    end

    // Operands for the edge about to enter ISSUE are prepared one cycle early so the divider sees registers.
    always_comb begin
        op_load = start_acc || (advance && idx != 2'd2);
        op_idx  = start_acc ? 2'd0 : idx + 2'd1;
        px0 = start_acc ? x0 : vx0;
        py0 = start_acc ? y0 : vy0;
        px1 = start_acc ? x1 : vx1;
        py1 = start_acc ? y1 : vy1;
        px2 = start_acc ? x2 : vx2;
        py2 = start_acc ? y2 : vy2;
        case (op_idx)
            2'd0:    begin ax = px0; ay = py0; bx = px1; by = py1; end
            2'd1:    begin ax = px0; ay = py0; bx = px2; by = py2; end
            default: begin ax = px1; ay = py1; bx = px2; by = py2; end
        endcase
        dx    = {bx[15], bx} - {ax[15], ax};
        dy    = {by[15], by} - {ay[15], ay};
        num_w = {{8{dx[16]}}, dx} << FRAC_BITS;
        den_w = {{8{dy[16]}}, dy};
        num   = sat16(num_w);
        den   = sat16(den_w);
        wr_val = (state == WAIT) ? div.div_quotient : 16'sd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            idx              <= 2'd0;
            vx0 <= '0; vy0 <= '0; vx1 <= '0; vy1 <= '0; vx2 <= '0; vy2 <= '0;
            slope01          <= '0;
            slope02          <= '0;
            slope12          <= '0;
            div.div_dividend <= '0;
            div.div_divisor  <= '0;
        end else begin
            state <= state_nxt;
            if (start_acc) begin
                vx0 <= x0; vy0 <= y0; vx1 <= x1; vy1 <= y1; vx2 <= x2; vy2 <= y2;
                idx <= 2'd0;
            end else if (advance && idx != 2'd2) begin
                idx <= idx + 2'd1;
            end
            if (op_load) begin
                div.div_dividend <= num;
                div.div_divisor  <= den;
            end
            if (advance) begin
                case (idx)
                    2'd0:    slope01 <= wr_val;
                    2'd1:    slope02 <= wr_val;
                    default: slope12 <= wr_val;
                endcase
            end
        end
    end

    assign busy         = (state != IDLE);
    assign done         = (state == DONE);
    assign div.div_open = (state == ISSUE) && (div.div_divisor != 16'sd0);

endmodule
